cmd_master: RTL and testbench
=============================

# cmd_master

Host-side command initiator for the logic analyzer's UART command link. It drives the opposite end of the command/response protocol from the on-chip command processor. It accepts a 16-bit command, transmits it as two bytes (high byte first) through a byte-level UART transmitter, then collects the response bytes from a byte-level UART receiver:
- one byte for reads, writes and invalid dumps;
- ENTRIES bytes for a valid channel dump.

It serves as the host model in system benches and as the command source for on-board self-test.

## Interface
- ENTRIES, 384, bytes returned by a valid dump (12288 on DE-0)
- LOG2, 9, width of the dump address space; rx_cnt is LOG2+1 bits
- TIMEOUT, 4096, idle cycles in RX_WAIT before a response is declared lost

- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- cmd  input  16  command; sampled only in IDLE when snd_cmd=1
- snd_cmd  input  1  start request
- tx_data  output  8  byte to UART transmitter
- trmt  output  1  one-cycle pulse to start a byte transmission
- tx_done  input  1  one-cycle pulse when the transmitter finishes a byte
- rx_data  input  8  byte from UART receiver
- rx_rdy  input  1  level; receiver holds a byte
- clr_rx_rdy  output  1  one-cycle pulse that knocks down rx_rdy
- resp  output  8  last response byte received
- resp_vld  output  1  one-cycle pulse when resp is updated
- rx_cnt  output  LOG2+1  response bytes received for the current command
- busy  output  1  high in every state except IDLE
- cmd_cmplt  output  1  level; set at normal or timed-out end, cleared on the next accepted snd_cmd
- timeout_err  output  1  level; set on timeout, cleared on the next accepted snd_cmd

## Operation
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; all outputs 0, including tx_data, resp, rx_cnt and all pulses/flags.
- Expected response count, latched at accept:
  - ENTRIES if cmd[15:14]=2'b10 and cmd[10:8] is in 1..5;
  - otherwise 1 (reads, writes, invalid dump channel 0/6/7 answered with 0xEE).
- Command register: holds cmd and the expected count from accept until return to IDLE.
- All outputs are registered.

States:
- IDLE:
  - snd_cmd=1: latch cmd; tx_data<=cmd[15:8]; trmt<=1; rx_cnt<=0; clear cmd_cmplt and timeout_err; go to TX_HI.
- TX_HI:
  - wait for tx_done;
  - on tx_done: tx_data<=cmd[7:0], trmt<=1, go to TX_LO.
- TX_LO:
  - wait for tx_done;
  - on tx_done: clear the timeout counter, go to RX_WAIT.
- RX_WAIT:
  - rx_rdy=1: resp<=rx_data; resp_vld<=1; clr_rx_rdy<=1; rx_cnt<=rx_cnt+1; clear the timeout counter; go to RX_ACK.
  - Otherwise increment the timeout counter. If the counter equals TIMEOUT-1: timeout_err<=1, cmd_cmplt<=1, go to IDLE.
- RX_ACK:
  - rx_rdy is ignored in this state, so the byte being cleared is not double-counted;
  - if rx_cnt equals the expected count: cmd_cmplt<=1, go to IDLE;
  - otherwise go to RX_WAIT.

Boundary conditions:
- snd_cmd while busy: ignored; cmd is not resampled.
- rx_rdy asserted during TX_HI/TX_LO: not consumed, left pending, taken in the first RX_WAIT cycle.
- tx_done in IDLE/RX states: ignored.
- Reset mid-operation: immediate return to IDLE with all outputs 0; a partial dump is discarded.
- rx_cnt: never wraps, since ENTRIES < 2^(LOG2+1). It holds its final value until the next accept.

## Timing
- trmt timing:
  - high byte: trmt is high the cycle after snd_cmd is sampled;
  - low byte: trmt is high the cycle after the first tx_done.
  - trmt is exactly one cycle wide each time; tx_data is valid in that cycle and held until the next load.
- Receive handshake:
  - resp, resp_vld and clr_rx_rdy appear the cycle after rx_rdy is sampled in RX_WAIT.
  - Minimum spacing between resp_vld pulses is 2 cycles.
- Completion: cmd_cmplt rises the cycle after the RX_ACK of the last byte, and busy falls on the same edge.
- Timeout: after exactly TIMEOUT consecutive RX_WAIT cycles with rx_rdy=0, timeout_err and cmd_cmplt rise together and busy falls.
- Back-to-back: a new snd_cmd is accepted in the first IDLE cycle after completion.

## Test plan
- Write: cmd=0x4706, responder returns 0xA5 -> tx_data 0x47 then 0x06 with one trmt pulse each; one resp_vld with resp=0xA5; rx_cnt=1; cmd_cmplt=1; timeout_err=0.
- Read: cmd=0x0D00, responder returns 0x06 -> resp=0x06, rx_cnt=1, cmd_cmplt=1.
- Dump, ENTRIES=384: cmd=0x8100, responder streams 384 bytes 0x00..0x7F repeating -> exactly 384 resp_vld pulses in order; rx_cnt=384; cmd_cmplt rises after the 384th byte and not before.
- Invalid dump: cmd=0x8700, responder returns 0xEE -> single byte; rx_cnt=1; cmd_cmplt=1.
- Timeout, TIMEOUT=16: cmd=0x0000, no response -> timeout_err and cmd_cmplt rise exactly 16 cycles after entry to RX_WAIT; busy=0.
- Robustness:
  - snd_cmd pulsed during TX_LO with a different cmd -> ignored; the original transaction completes unchanged.
  - rst_n asserted after 100 dump bytes -> all outputs 0 immediately; a fresh cmd=0x4706 then completes normally.

Source files
------------

// File: rtl/cmd_master.sv
// Host-side UART command initiator: sends a 16-bit command as two bytes (high
// first), then collects one response byte, or ENTRIES bytes for a valid dump.
module cmd_master #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     cmd,
  input  logic            snd_cmd,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  input  logic [7:0]      rx_data,
  input  logic            rx_rdy,
  output logic            clr_rx_rdy,
  output logic [7:0]      resp,
  output logic            resp_vld,
  output logic [LOG2:0]   rx_cnt,
  output logic            busy,
  output logic            cmd_cmplt,
  output logic            timeout_err
);

  localparam int CW = LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, TX_HI, TX_LO, RX_WAIT, RX_ACK} state_t;

  state_t          state, state_n;
  logic [7:0]      cmd_lo, cmd_lo_n;
  logic [CW-1:0]   exp_cnt, exp_cnt_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic [7:0]      tx_data_n, resp_n;
  logic            trmt_n, clr_n, vld_n, busy_n, cmplt_n, terr_n;
  logic [CW-1:0]   rx_cnt_n;
  logic            dump_ok;

  // Only dumps of channels 1..5 stream a full buffer; everything else answers once.
  assign dump_ok = (cmd[15:14] == 2'b10) && (cmd[10:8] != 3'd0) && (cmd[10:8] <= 3'd5);

  always_comb begin
    state_n   = state;
    cmd_lo_n  = cmd_lo;
    exp_cnt_n = exp_cnt;
    tmo_n     = tmo;
    tx_data_n = tx_data;
    resp_n    = resp;
    rx_cnt_n  = rx_cnt;
    cmplt_n   = cmd_cmplt;
    terr_n    = timeout_err;
    trmt_n    = 1'b0;
    clr_n     = 1'b0;
    vld_n     = 1'b0;
    case (state)
      IDLE: begin
        if (snd_cmd) begin
          cmd_lo_n  = cmd[7:0];
          exp_cnt_n = dump_ok ? CW'(ENTRIES) : CW'(1);
          tx_data_n = cmd[15:8];
          trmt_n    = 1'b1;
          rx_cnt_n  = '0;
          cmplt_n   = 1'b0;
          terr_n    = 1'b0;
          state_n   = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          tx_data_n = cmd_lo;
          trmt_n    = 1'b1;
          state_n   = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          tmo_n   = '0;
          state_n = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (rx_rdy) begin
          resp_n   = rx_data;
          vld_n    = 1'b1;
          clr_n    = 1'b1;
          rx_cnt_n = rx_cnt + 1'b1;
          tmo_n    = '0;
          state_n  = RX_ACK;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          terr_n  = 1'b1;
          cmplt_n = 1'b1;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
      RX_ACK: begin
        if (rx_cnt == exp_cnt) begin
          cmplt_n = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = RX_WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_lo      <= '0;
      exp_cnt     <= '0;
      tmo         <= '0;
      tx_data     <= '0;
      trmt        <= 1'b0;
      clr_rx_rdy  <= 1'b0;
      resp        <= '0;
      resp_vld    <= 1'b0;
      rx_cnt      <= '0;
      busy        <= 1'b0;
      cmd_cmplt   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_lo      <= cmd_lo_n;
      exp_cnt     <= exp_cnt_n;
      tmo         <= tmo_n;
      tx_data     <= tx_data_n;
      trmt        <= trmt_n;
      clr_rx_rdy  <= clr_n;
      resp        <= resp_n;
      resp_vld    <= vld_n;
      rx_cnt      <= rx_cnt_n;
      busy        <= busy_n;
      cmd_cmplt   <= cmplt_n;
      timeout_err <= terr_n;
    end
  end

endmodule

// File: tb/tb_cmd_master.sv
// Bench for cmd_master: directed and randomized command transactions against a
// behavioural model of the command/response protocol.
module tb_cmd_master;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   cmd;
  logic          snd_cmd, tx_done, rx_rdy;
  logic [7:0]    rx_data;
  logic [7:0]    tx_data, resp;
  logic          trmt, clr_rx_rdy, resp_vld, busy, cmd_cmplt, timeout_err;
  logic [LOG2:0] rx_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] txq[$];
  logic [7:0] rq[$];

  cmd_master #(.ENTRIES(ENTRIES), .LOG2(LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd),
    .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .resp(resp), .resp_vld(resp_vld), .rx_cnt(rx_cnt), .busy(busy),
    .cmd_cmplt(cmd_cmplt), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Record every transmitted and received byte as the link would see them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (trmt) txq.push_back(tx_data);
      if (resp_vld) rq.push_back(resp);
    end
  end

  initial begin
    #5_000_000;
    $error("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_dump(input logic [15:0] c);
    int ch;
    ch = int'(c[10:8]);
    return (c[15:14] == 2'b10) && ch >= 1 && ch <= 5;
  endfunction

  function automatic int exp_count(input logic [15:0] c);
    return is_dump(c) ? ENTRIES : 1;
  endfunction

  function automatic logic [31:0] all_outs();
    return {tx_data, trmt, clr_rx_rdy, resp, resp_vld, rx_cnt, busy, cmd_cmplt, timeout_err};
  endfunction

  // One complete transaction. silent: no responder; early: first byte already
  // pending during TX_LO; intrude: foreign snd_cmd during TX_LO; abort_at: reset
  // before that response byte (-1 for none).
  task automatic do_cmd(input logic [15:0] c, input bit silent, input bit early,
                        input bit intrude, input int abort_at);
    int n;
    int waited;
    logic [7:0] bytes[$];
    n = exp_count(c);
    for (int i = 0; i < n; i++) begin
      if (is_dump(c))                bytes.push_back(8'(i % 128));
      else if (c[15:14] == 2'b10)    bytes.push_back(8'hEE);
      else                           bytes.push_back(8'($urandom));
    end
    txq.delete();
    rq.delete();

    cmd = c; snd_cmd = 1'b1;
    step();
    snd_cmd = 1'b0; cmd = 16'($urandom);
    chk("accept_trmt", 32'(trmt), 1);
    chk("hi_byte", 32'(tx_data), 32'(c[15:8]));
    chk("accept_busy", 32'(busy), 1);
    chk("flags_cleared", {cmd_cmplt, timeout_err, rx_cnt}, 0);

    repeat ($urandom_range(0, 3)) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("lo_trmt", 32'(trmt), 1);
    chk("lo_byte", 32'(tx_data), 32'(c[7:0]));

    for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
      if (intrude && j == 0) begin
        snd_cmd = 1'b1; cmd = ~c;
      end
      step();
      snd_cmd = 1'b0;
    end
    if (early && !silent) begin
      rx_data = bytes[0]; rx_rdy = 1'b1;
      step();
      chk("pending_not_taken", 32'(clr_rx_rdy), 0);
    end
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    if (silent) begin
      repeat (TIMEOUT - 1) step();
      chk("no_early_timeout", {timeout_err, cmd_cmplt, busy}, 32'b001);
      step();
      chk("timeout_flags", {timeout_err, cmd_cmplt, busy}, 32'b110);
      chk("timeout_rx_cnt", 32'(rx_cnt), 0);
      chk("timeout_tx", 32'(txq.size()), 2);
      return;
    end

    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outs", all_outs(), 0);
        step();
        rst_n = 1'b1; rx_rdy = 1'b0;
        step();
        chk("after_reset_idle", all_outs(), 0);
        return;
      end
      if (!(early && i == 0)) begin
        repeat ($urandom_range(0, 3)) step();
        rx_data = bytes[i]; rx_rdy = 1'b1;
      end
      waited = 0;
      step();
      while (clr_rx_rdy !== 1'b1 && waited < 8) begin
        step();
        waited++;
      end
      rx_rdy = 1'b0;
      chk("clr_rx_rdy", 32'(clr_rx_rdy), 1);
      if (clr_rx_rdy !== 1'b1) return;
      chk("resp", {resp_vld, resp}, {1'b1, bytes[i]});
      chk("rx_cnt", 32'(rx_cnt), i + 1);
      step();
      if (i < n - 1) chk("not_done_early", {cmd_cmplt, busy}, 32'b01);
      else           chk("completion", {cmd_cmplt, timeout_err, busy}, 32'b100);
    end
    chk("tx_count", 32'(txq.size()), 2);
    if (txq.size() == 2) chk("tx_bytes", {txq[0], txq[1]}, 32'(c));
    chk("resp_count", 32'(rq.size()), n);
    chk("final_rx_cnt", 32'(rx_cnt), n);
  endtask

  initial begin
    logic [15:0] rc;
    rst_n = 1'b0; cmd = '0; snd_cmd = 1'b0; tx_done = 1'b0;
    rx_rdy = 1'b0; rx_data = '0;
    step();
    step();
    chk("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    step();

    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("idle_tx_done_ignored", {busy, trmt}, 0);

    do_cmd(16'h4706, 0, 0, 0, -1);
    do_cmd(16'h0D00, 0, 0, 0, -1);
    do_cmd(16'h8100, 0, 0, 0, -1);
    do_cmd(16'h8700, 0, 0, 0, -1);
    do_cmd(16'h0000, 1, 0, 0, -1);
    do_cmd(16'h4706, 0, 1, 1, -1);
    do_cmd(16'h8300, 0, 0, 0, 100);
    do_cmd(16'h4706, 0, 0, 0, -1);

    for (int t = 0; t < 8; t++) begin
      rc = 16'($urandom);
      do_cmd(rc, 0, 1'($urandom), 1'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
